// File: rtl/reg_writeback.sv
// Register-file write-port arbiter: ALU results win, colliding load results queue in a small FIFO.
// Optional pending-target mask output enabled by `REG_WRITEBACK_PENDING_MASK_EN.
module reg_writeback #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk_w_i,
  input  logic          res_w_i_h,
  input  logic          alu_valid_w_i,
  input  logic [4:0]    alu_rd_w_i,
  input  logic [31:0]   alu_data_w_i,
  input  logic          ld_valid_w_i,
  output logic          ld_ready_w_o,
  input  logic [4:0]    ld_rd_w_i,
  input  logic [31:0]   ld_data_w_i,
  output logic [4:0]    wr_reg_w_o,
  output logic [31:0]   wr_data_w_o,
  output logic          reg_wr_flag_w_o,
  output logic [AW:0]   fifo_cnt_w_o
`ifdef REG_WRITEBACK_PENDING_MASK_EN
  ,
  output logic [31:0]   pend_mask_w_o
`endif
);

  logic [4:0]    fifo_rd_q   [DEPTH];
  logic [31:0]   fifo_data_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q, cnt_d;

  logic [4:0]    wr_reg_q, wr_reg_d;
  logic [31:0]   wr_data_q, wr_data_d;
  logic          flag_q, flag_d;

  logic          ld_ready;
  logic          ld_xfer;
  logic          push;
  logic          pop;
  logic          bypass;

  always_comb begin
    ld_ready  = (cnt_q != (AW+1)'(DEPTH)) && !res_w_i_h;
    ld_xfer   = ld_valid_w_i && ld_ready;
    wr_reg_d  = wr_reg_q;
    wr_data_d = wr_data_q;
    flag_d    = 1'b0;
    pop       = 1'b0;
    bypass    = 1'b0;

    // An ALU write to x0 still owns the port this cycle, so it blocks the pop.
    if (alu_valid_w_i) begin
      if (alu_rd_w_i != 5'd0) begin
        flag_d    = 1'b1;
        wr_reg_d  = alu_rd_w_i;
        wr_data_d = alu_data_w_i;
      end
    end else if (cnt_q != '0) begin
      pop       = 1'b1;
      flag_d    = 1'b1;
      wr_reg_d  = fifo_rd_q[rd_ptr_q];
      wr_data_d = fifo_data_q[rd_ptr_q];
    end else if (ld_xfer && (ld_rd_w_i != 5'd0)) begin
      bypass    = 1'b1;
      flag_d    = 1'b1;
      wr_reg_d  = ld_rd_w_i;
      wr_data_d = ld_data_w_i;
    end

    // Loads to x0 complete the handshake but are never stored.
    push = ld_xfer && (ld_rd_w_i != 5'd0) && !bypass;

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_w_i) begin
    if (res_w_i_h) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
      flag_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q     <= cnt_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
      flag_q    <= flag_d;
    end
  end

  // Storage has no reset; push is already held off while reset is high.
  always_ff @(posedge clk_w_i) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= ld_rd_w_i;
      fifo_data_q[wr_ptr_q] <= ld_data_w_i;
    end
  end

  assign ld_ready_w_o    = ld_ready;
  assign wr_reg_w_o      = wr_reg_q;
  assign wr_data_w_o     = wr_data_q;
  assign reg_wr_flag_w_o = flag_q;
  assign fifo_cnt_w_o    = cnt_q;

`ifdef REG_WRITEBACK_PENDING_MASK_EN
  logic [DEPTH-1:0] slot_valid;
  logic [31:0]      pend_mask;

  // A slot is live when its distance from the read pointer is below the occupancy.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [AW-1:0] offset;
    assign offset         = AW'(gi) - rd_ptr_q;
    assign slot_valid[gi] = ({1'b0, offset} < cnt_q);
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_valid[i]) pend_mask[fifo_rd_q[i]] = 1'b1;
    end
    pend_mask[0] = 1'b0;
    if (res_w_i_h) pend_mask = '0;
  end

  assign pend_mask_w_o = pend_mask;
`endif

endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
- Write-side master for the `registers` block. Merges two result sources into the single register-file write port (`wr_reg`, `wr_data`, `reg_wr_flag`):
  - the ALU/execute stage: single-cycle, no backpressure;
  - the load unit: valid/ready.
- ALU results always take priority. Load results that collide with an ALU write are buffered in a small FIFO and drained in cycles with no ALU write.
- Sits between the execute/memory stages and `registers`.

Parameters:
- DEPTH, 4, load-buffer entries; power of 2, minimum 2.
- AW, 2, log2(DEPTH), pointer width.

Ports:
- clk_w_i  in  1  clock; all state changes on the rising edge.
- res_w_i_h  in  1  reset, synchronous, active-high.
- alu_valid_w_i  in  1  ALU result valid this cycle; always accepted.
- alu_rd_w_i  in  5  ALU destination register.
- alu_data_w_i  in  32  ALU result.
- ld_valid_w_i  in  1  load result valid.
- ld_ready_w_o  out  1  block can accept a load result this cycle.
- ld_rd_w_i  in  5  load destination register.
- ld_data_w_i  in  32  load data.
- wr_reg_w_o  out  5  to registers `wr_reg_w_i`.
- wr_data_w_o  out  32  to registers `wr_data_w_i`.
- reg_wr_flag_w_o  out  1  to registers `reg_wr_flag_w_i`.
- fifo_cnt_w_o  out  AW+1  current load-buffer occupancy, 0..DEPTH.

Behaviour:
- Clocking and reset:
  - One clock, `clk_w_i`.
  - `res_w_i_h` is synchronous and active-high. While sampled high on a rising edge, all state clears.
- Reset values:
  - `wr_reg_w_o` = 0, `wr_data_w_o` = 0, `reg_wr_flag_w_o` = 0.
  - FIFO read/write pointers = 0; `fifo_cnt_w_o` = 0.
  - `ld_ready_w_o` = 0 while `res_w_i_h` is high. It is combinational, so it rises in the cycle reset deasserts.
- Reset mid-operation: buffered loads are discarded. Any handshake in the reset cycle is ignored.
- Output registers:
  - `wr_*` and `reg_wr_flag_w_o` are registered: 1-cycle latency from the accepting edge.
  - They are valid for exactly one cycle per write. `reg_wr_flag_w_o` returns to 0 in idle cycles.
  - `wr_reg_w_o` and `wr_data_w_o` hold their last value when the flag is 0.
- Load handshake:
  - `ld_ready_w_o` = (count != DEPTH) and not `res_w_i_h`.
  - A transfer occurs when `ld_valid_w_i` and `ld_ready_w_o` are both high at a rising edge.
  - When full, ready stays 0 even if a pop happens that cycle (no full-cycle pass-through).
- Per-edge decision, in priority order:
  1. ALU: if `alu_valid_w_i` is high, output `alu_rd`/`alu_data`. Flag = (`alu_rd_w_i` != 0).
  2. Otherwise, if count > 0: pop the FIFO head to the output with flag = 1.
  3. Otherwise, if a load transfers: bypass the FIFO and output `ld_rd`/`ld_data` directly, flag = 1.
  4. Otherwise: flag = 0.
- Load enqueue: a transferred load is enqueued in every case except the bypass in step 3.
  - Push and pop in the same edge are allowed; count is unchanged.
- x0 handling:
  - A load with `ld_rd_w_i` == 0 is accepted (handshake completes) and dropped: never enqueued, never written.
  - An ALU write to x0 does not raise the flag, but it still occupies the port for that cycle (no pop).
- Ordering:
  - Loads are written strictly in acceptance order.
  - No reordering between ALU and load writes is detected; the pipeline's hazard logic owns that.
- FIFO pointers wrap modulo DEPTH. `fifo_cnt_w_o` never exceeds DEPTH and never underflows.

Optional Feature:
- Macro: `REG_WRITEBACK_PENDING_MASK_EN`.
- When defined:
  - Adds output `pend_mask_w_o` (out, 32): bit r = 1 iff any valid FIFO entry targets register r.
  - Bit 0 is always 0.
  - Combinational from FIFO contents; all zeros in reset.
  - Used by the hazard unit to stall reads of in-flight load targets.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then `alu_valid`=1, rd=5, data=0xDEADBEEF for one cycle -> next cycle flag=1, wr_reg=5, wr_data=0xDEADBEEF; the cycle after, flag=0.
- FIFO empty, no ALU; load rd=7, data=0x12345678 with valid=1 -> ready=1; next cycle written directly; `fifo_cnt` stays 0.
- ALU valid (rd=1..5) for 5 consecutive cycles while loads rd=10,11,12,13 are offered -> 4 accepted, `fifo_cnt`=4, ready=0 on the 5th. Once the ALU goes idle: writes 10, 11, 12, 13 on consecutive cycles, then count=0 and ready=1.
- ALU rd=0, data=0xFFFFFFFF, plus load rd=0 -> flag stays 0 for both; `fifo_cnt` stays 0; load handshake completes.
- With 3 loads buffered, assert `res_w_i_h` for 1 cycle -> `fifo_cnt`=0, flag=0, no buffered write ever appears; with the macro defined, `pend_mask`=0.
- Macro defined; buffer loads rd=3 and rd=3 -> `pend_mask`=0x00000008 until the second rd=3 entry pops, then 0.
